// File: rtl/codec_cfg_seq_pkg.sv
// Shared types and constants for the codec configuration sequencer.
// The 24-bit table word is {dev_addr, reg_hi, reg_lo/data}.
package codec_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } cfg_state_t;

    localparam int WORD_W  = 24;
    localparam int DEV_MSB = 23;
    localparam int DEV_LSB = 16;

    localparam logic [7:0] CODEC_ADDR = 8'h34;
    localparam logic [7:0] AUX_ADDR   = 8'h40;

endpackage

// File: rtl/codec_cfg_seq_tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clocks.
// Reusable wherever a slow step rate is needed without a derived clock.
module cfg_tick_gen #(
    parameter int DIV = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_last;

endmodule

// File: rtl/codec_cfg_seq.sv
// Walks an external configuration table and issues one 24-bit I2C write per entry,
// with bounded retries, an END watchdog and done/err status.
//   state | meaning
//   IDLE  | waiting for auto-start, start pulse or mode change
//   LOAD  | one clock for the table to settle, then latch the word
//   SEND  | raise GO, clear watchdog
//   WAIT  | wait for END (ACK/NACK) or watchdog expiry
//   NEXT  | advance index or finish
//   DONE  | report success
//   FAIL  | report abort
module codec_cfg_seq
    import codec_cfg_seq_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int I2C_FREQ   = 20000,
    parameter int LUT_SIZE   = 51,
    parameter int IDX_W      = 6,
    parameter int MODE_W     = 2,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 64,
    parameter int AUTO_START = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    output logic [IDX_W-1:0]  lut_index,
    output logic [MODE_W-1:0] lut_mode,
    input  logic [WORD_W-1:0] lut_data,
    output logic              i2c_tick,
    output logic [WORD_W-1:0] i2c_data,
    output logic              i2c_go,
    input  logic              i2c_end,
    input  logic              i2c_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  err_index
);
    localparam int DIV     = CLK_FREQ / I2C_FREQ;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LUT_SIZE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);

    logic w_tick;

    cfg_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk  (CLK),
        .i_rst  (RST),
        .o_tick (w_tick)
    );

    cfg_state_t          r_state,       w_state_nxt;
    logic [IDX_W-1:0]    r_index,       w_index_nxt;
    logic [MODE_W-1:0]   r_mode,        w_mode_nxt;
    logic [WORD_W-1:0]   r_data,        w_data_nxt;
    logic                r_go,          w_go_nxt;
    logic                r_busy,        w_busy_nxt;
    logic                r_done,        w_done_nxt;
    logic                r_err,         w_err_nxt;
    logic [IDX_W-1:0]    r_err_index,   w_err_index_nxt;
    logic [RETRY_W-1:0]  r_retry,       w_retry_nxt;
    logic [WD_W-1:0]     r_wd,          w_wd_nxt;
    logic                r_start_pend,  w_start_pend_nxt;
    logic                r_auto_pend,   w_auto_pend_nxt;
    logic                w_trigger;
    logic                w_fail;

    // start, auto-start and a mode change all collapse into one pass request
    assign w_trigger = r_start_pend | start | r_auto_pend | (mode != r_mode);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_mode       <= '0;
            r_data       <= '0;
            r_go         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_index  <= '0;
            r_retry      <= '0;
            r_wd         <= '0;
            r_start_pend <= 1'b0;
            r_auto_pend  <= (AUTO_START != 0);
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_mode       <= w_mode_nxt;
            r_data       <= w_data_nxt;
            r_go         <= w_go_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_err_index  <= w_err_index_nxt;
            r_retry      <= w_retry_nxt;
            r_wd         <= w_wd_nxt;
            r_start_pend <= w_start_pend_nxt;
            r_auto_pend  <= w_auto_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_index_nxt      = r_index;
        w_mode_nxt       = r_mode;
        w_data_nxt       = r_data;
        w_go_nxt         = r_go;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;
        w_err_index_nxt  = r_err_index;
        w_retry_nxt      = r_retry;
        w_wd_nxt         = r_wd;
        w_auto_pend_nxt  = r_auto_pend;
        w_fail           = 1'b0;
        w_start_pend_nxt = (r_state == ST_IDLE) ? (r_start_pend | start) : 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_tick && w_trigger) begin
                    w_state_nxt      = ST_LOAD;
                    w_mode_nxt       = mode;
                    w_index_nxt      = '0;
                    w_retry_nxt      = '0;
                    w_done_nxt       = 1'b0;
                    w_err_nxt        = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_start_pend_nxt = 1'b0;
                    w_auto_pend_nxt  = 1'b0;
                end
            end
            ST_LOAD: begin
                w_data_nxt  = lut_data;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_tick) begin
                    w_go_nxt    = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_tick) begin
                    if (i2c_end) begin
                        w_go_nxt = 1'b0;
                        if (!i2c_ack) begin
                            w_state_nxt = ST_NEXT;
                        end else begin
                            w_fail = 1'b1;
                        end
                    end else begin
                        w_wd_nxt = r_wd + 1'b1;
                        if (r_wd == WD_LAST) begin
                            w_go_nxt = 1'b0;
                            w_fail   = 1'b1;
                        end
                    end
                end
            end
            ST_NEXT: begin
                if (w_tick) begin
                    if (r_index == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                        w_retry_nxt = '0;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                if (w_tick) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (w_tick) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // a retry resends the already latched word, so GO never rises on stale data
        if (w_fail) begin
            if (r_retry < RETRY_MAX) begin
                w_retry_nxt = r_retry + 1'b1;
                w_state_nxt = ST_SEND;
            end else begin
                w_err_index_nxt = r_index;
                w_state_nxt     = ST_FAIL;
            end
        end
    end

    assign lut_index = r_index;
    assign lut_mode  = r_mode;
    assign i2c_tick  = w_tick;
    assign i2c_data  = r_data;
    assign i2c_go    = r_go;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign err_index = r_err_index;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboard bench for codec_cfg_seq: a reference model predicts every I2C attempt
// and pass outcome; a monitor thread compares them as the DUT presents GO rises and pass ends.
module tb_codec_cfg_seq;
    import codec_cfg_seq_pkg::*;

    localparam int N_ENT   = 4;
    localparam int RETRIES = 3;
    localparam int TMO     = 8;
    localparam int HANG    = -1;
    localparam int ALWAYS  = 99;

    typedef struct {
        int          idx;
        logic [1:0]  mode;
        logic [23:0] data;
    } attempt_t;

    typedef struct {
        bit done;
        bit err;
        int eidx;
    } status_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  lut_index;
    logic [1:0]  lut_mode;
    logic [23:0] lut_data;
    logic        i2c_tick;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic        i2c_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_index;

    int n_tests = 0;
    int n_fail  = 0;

    int       plan [N_ENT];
    attempt_t exp_q [$];
    status_t  exp_st [$];
    logic [1:0] cur_mode;

    always #5 CLK = ~CLK;

    codec_cfg_seq #(
        .CLK_FREQ   (400),
        .I2C_FREQ   (100),
        .LUT_SIZE   (N_ENT),
        .IDX_W      (3),
        .MODE_W     (2),
        .MAX_RETRY  (RETRIES),
        .TIMEOUT    (TMO),
        .AUTO_START (1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .mode      (mode),
        .lut_index (lut_index),
        .lut_mode  (lut_mode),
        .lut_data  (lut_data),
        .i2c_tick  (i2c_tick),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .i2c_end   (i2c_end),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_index (err_index)
    );

    function automatic logic [23:0] table_word(input logic [1:0] m, input int i);
        logic [23:0] w;
        w[DEV_MSB:DEV_LSB] = i[0] ? AUX_ADDR : CODEC_ADDR;
        w[15:0] = {6'(i), m, 8'h5A ^ 8'(i * 17)};
        if (m == 2'd1 && i == 1) w = {CODEC_ADDR, 16'h0815};
        return w;
    endfunction

    assign lut_data = table_word(lut_mode, int'(lut_index));

    // Controller model: answers each GO after a random number of ticks, NACKing
    // the first plan[idx] attempts of an entry; HANG entries never return END.
    int att_cnt [N_ENT];
    bit c_active;
    int c_lat;
    int c_idx;
    always @(negedge CLK) begin
        i2c_end = 1'b0;
        i2c_ack = 1'b0;
        if (RST || !busy) begin
            c_active = 1'b0;
            for (int k = 0; k < N_ENT; k++) att_cnt[k] = 0;
        end else if (i2c_tick) begin
            if (!i2c_go) begin
                c_active = 1'b0;
            end else if (!c_active) begin
                c_active = 1'b1;
                c_lat    = int'($urandom_range(1, 3));
                c_idx    = int'(lut_index) % N_ENT;
            end else begin
                c_lat--;
                if (c_lat == 0 && plan[c_idx] != HANG) begin
                    i2c_end = 1'b1;
                    i2c_ack = (att_cnt[c_idx] < plan[c_idx]);
                    att_cnt[c_idx]++;
                    c_active = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: each entry fails plan[i] times (HANG and ALWAYS fail forever);
    // an entry is attempted min(fails, RETRIES)+1 times and aborts the pass if fails > RETRIES.
    task automatic push_pass(input logic [1:0] m);
        status_t s;
        s.done = 1'b1;
        s.err  = 1'b0;
        s.eidx = 0;
        for (int i = 0; i < N_ENT; i++) begin
            int fails;
            int tries;
            fails = (plan[i] == HANG) ? RETRIES + 1 : plan[i];
            tries = (fails > RETRIES) ? RETRIES + 1 : fails + 1;
            for (int a = 0; a < tries; a++) exp_q.push_back('{i, m, table_word(m, i)});
            if (fails > RETRIES) begin
                s.done = 1'b0;
                s.err  = 1'b1;
                s.eidx = i;
                break;
            end
        end
        exp_st.push_back(s);
    endtask

    task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
        plan[0] = p0;
        plan[1] = p1;
        plan[2] = p2;
        plan[3] = p3;
    endtask

    task automatic monitor();
        logic     prev_go   = 1'b0;
        logic     prev_busy = 1'b0;
        int       go_len    = 0;
        bit       cur_hang  = 1'b0;
        attempt_t a;
        status_t  s;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_go   = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            if (i2c_go && !prev_go) begin
                go_len   = 0;
                cur_hang = (plan[int'(lut_index) % N_ENT] == HANG);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_go: index %0d data %06h, no attempt expected", lut_index, i2c_data);
                end else begin
                    a = exp_q.pop_front();
                    check("go_index", 32'(lut_index), 32'(a.idx));
                    check("go_data", 32'(i2c_data), 32'(a.data));
                    check("go_mode", 32'(lut_mode), 32'(a.mode));
                end
            end
            if (i2c_go && i2c_tick) go_len++;
            if (!i2c_go && prev_go && cur_hang) check("go_hold_ticks", 32'(go_len), 32'(TMO));
            if (!busy && prev_busy) begin
                n_tests++;
                if (exp_st.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pass_end: done=%0b err=%0b, no pass expected", done, err);
                end else begin
                    s = exp_st.pop_front();
                    check("pass_done", 32'(done), 32'(s.done));
                    check("pass_err", 32'(err), 32'(s.err));
                    if (s.err) check("pass_err_index", 32'(err_index), 32'(s.eidx));
                    check("attempts_left", 32'(exp_q.size()), 32'd0);
                end
            end
            prev_go   = i2c_go;
            prev_busy = busy;
        end
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string what);
        int n = 0;
        while (busy !== lvl && n < limit) begin
            @(negedge CLK);
            n++;
        end
        n_tests++;
        if (busy !== lvl) begin
            n_fail++;
            $display("FAIL %s: busy=%0b after %0d cycles, required %0b", what, busy, n, lvl);
        end
    endtask

    task automatic wait_pass(input string what);
        wait_busy(1'b1, 100, {what, "_begin"});
        wait_busy(1'b0, 5000, {what, "_end"});
        repeat (2) @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_go"}, 32'(i2c_go), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_index"}, 32'(lut_index), 32'd0);
        check({tag, "_mode"}, 32'(lut_mode), 32'd0);
        check({tag, "_data"}, 32'(i2c_data), 32'd0);
        check({tag, "_err_index"}, 32'(err_index), 32'd0);
        check({tag, "_tick"}, 32'(i2c_tick), 32'd0);
    endtask

    initial begin
        int n;
        RST      = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        cur_mode = 2'd0;
        set_plan(0, 0, 0, 0);
        fork
            monitor();
        join_none

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");

        // auto-start after reset, every entry acknowledged
        push_pass(2'd0);
        @(negedge CLK);
        RST = 1'b0;
        wait_pass("auto_pass");

        // entry 2 NACKs twice, third attempt succeeds
        set_plan(0, 0, 2, 0);
        push_pass(cur_mode);
        pulse_start();
        wait_pass("retry_pass");

        // entry 1 always NACKs: abort after 1+RETRIES attempts
        set_plan(0, ALWAYS, 0, 0);
        push_pass(cur_mode);
        pulse_start();
        wait_pass("nack_pass");

        // entry 0 never returns END: watchdog on every attempt
        set_plan(HANG, 0, 0, 0);
        push_pass(cur_mode);
        pulse_start();
        wait_pass("hang_pass");
        repeat (160) @(negedge CLK);
        check("idle_after_err", 32'(busy), 32'd0);

        // mode change starts a pass; a start pulse mid-pass is dropped
        set_plan(0, 0, 0, 0);
        push_pass(2'd1);
        @(negedge CLK);
        mode     = 2'd1;
        cur_mode = 2'd1;
        wait_busy(1'b1, 100, "mode_pass_begin");
        repeat (10) @(negedge CLK);
        pulse_start();
        wait_busy(1'b0, 5000, "mode_pass_end");
        repeat (160) @(negedge CLK);
        check("no_extra_pass", 32'(busy), 32'd0);
        check("mode_kept", 32'(lut_mode), 32'd1);

        // randomized passes: random per-entry failure counts and mode
        for (int r = 0; r < 6; r++) begin
            logic [1:0] m;
            for (int i = 0; i < N_ENT; i++)
                plan[i] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
            m = 2'($urandom_range(0, 3));
            push_pass(m);
            if (m != cur_mode) begin
                @(negedge CLK);
                mode = m;
            end else begin
                pulse_start();
            end
            cur_mode = m;
            wait_pass("rand_pass");
        end

        // reset while GO is high abandons the pass; a fresh pass follows
        set_plan(0, 0, 0, 0);
        push_pass(cur_mode);
        pulse_start();
        n = 0;
        while (i2c_go !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("go_before_reset", 32'(i2c_go), 32'd1);
        #3;
        RST = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_st.delete();
        repeat (3) @(negedge CLK);
        push_pass(cur_mode);
        RST = 1'b0;
        wait_pass("restart_pass");
        check("restart_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
